cand_sweep_ctrl: RTL

CAND_SWEEP_CTRL -- requirements
Module: cand_sweep_ctrl

---
 rtl/icblbc_pkg.sv | 16 +
 rtl/cand_sweep_ctrl_popcount8.sv | 17 +
 rtl/cand_sweep_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/icblbc_pkg.sv
// Shared definitions for the candidate sweep controller:
// default widths, distance width and FSM state encoding.
package icblbc_pkg;

    localparam int CODE_W_DEF = 8;
    localparam int LEN_W_DEF  = 9;
    localparam int DIST_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cand_sweep_ctrl_popcount8.sv
// popcount8: combinational set-bit count of an 8-bit value.
// Ports: val_i (8-bit operand), cnt_o (number of ones, 0..8).
module popcount8
    import icblbc_pkg::*;
(
    input  logic [7:0]        val_i,
    output logic [DIST_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < 8; k++) begin
            cnt_o = cnt_o + DIST_W'(val_i[k]);
        end
    end

endmodule

// File: rtl/cand_sweep_ctrl.sv
// cand_sweep_ctrl: streams L candidates from a source RAM, keeps those whose
// Hamming distance to a reference code is >= min_dist, packs them into a
// destination RAM from address 0 and reports the survivor count.
// Ports: clock, reset_n (sync, active-low), start, code, min_dist, cand_len,
//   rd_addr/rd_data (source RAM, 1-cycle latency), wr_en/wr_addr/wr_data
//   (survivor RAM), busy, done (1-cycle pulse), next_len (survivor count).
// Optional macro CAND_SWEEP_GEN_EN adds gen/n: generate candidates 0..2**n-1
// internally instead of reading the source RAM.
module cand_sweep_ctrl
    import icblbc_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic [DIST_W-1:0] min_dist,
    input  logic [LEN_W-1:0]  cand_len,
`ifdef CAND_SWEEP_GEN_EN
    input  logic              gen,
    input  logic [3:0]        n,
`endif
    output logic [CODE_W-1:0] rd_addr,
    input  logic [CODE_W-1:0] rd_data,
    output logic              wr_en,
    output logic [CODE_W-1:0] wr_addr,
    output logic [CODE_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  next_len
);

    state_e            state_q;
    logic [CODE_W-1:0] code_q;
    logic [DIST_W-1:0] min_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              v1_q;
    logic              v2_q;
    logic              wr_en_q;
    logic [CODE_W-1:0] wr_addr_q;
    logic [CODE_W-1:0] wr_data_q;
    logic              busy_q;
    logic              done_q;
    logic [LEN_W-1:0]  next_len_q;

    logic [LEN_W-1:0]  len_d;
    logic [CODE_W-1:0] cand_d;
    logic [DIST_W-1:0] dist_d;
    logic              pass_d;

`ifdef CAND_SWEEP_GEN_EN
    logic              gen_q;
    // Address issued last cycle; it is the candidate itself in gen mode.
    logic [CODE_W-1:0] a2_q;

    always_comb begin
        len_d  = gen ? (LEN_W'(1) << n) : cand_len;
        cand_d = gen_q ? a2_q : rd_data;
    end
`else
    always_comb begin
        len_d  = cand_len;
        cand_d = rd_data;
    end
`endif

    popcount8 u_pop (
        .val_i (8'(code_q ^ cand_d)),
        .cnt_o (dist_d)
    );

    assign pass_d = v2_q && (dist_d >= min_q);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            code_q     <= '0;
            min_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            next_len_q <= '0;
`ifdef CAND_SWEEP_GEN_EN
            gen_q      <= 1'b0;
            a2_q       <= '0;
`endif
        end else begin
            // Read pipeline: v1 = address on rd_addr, v2 = data on rd_data.
            v2_q    <= v1_q;
            wr_en_q <= pass_d;
            done_q  <= 1'b0;
`ifdef CAND_SWEEP_GEN_EN
            a2_q    <= idx_q[CODE_W-1:0];
`endif
            if (pass_d) begin
                wr_addr_q <= cnt_q[CODE_W-1:0];
                wr_data_q <= cand_d;
                cnt_q     <= cnt_q + LEN_W'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        code_q <= code;
                        min_q  <= min_dist;
                        len_q  <= len_d;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef CAND_SWEEP_GEN_EN
                        gen_q  <= gen;
`endif
                        if (len_d == '0) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            next_len_q <= '0;
                        end else begin
                            state_q <= ST_ISSUE;
                            v1_q    <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (idx_q == len_q - LEN_W'(1)) begin
                        v1_q    <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else begin
                        idx_q <= idx_q + LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Last data was evaluated last cycle; count is final.
                    if (!v2_q) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        next_len_q <= cnt_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_addr  = idx_q[CODE_W-1:0];
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign next_len = next_len_q;

endmodule
